mem_arbiter: RTL and testbench

- Sole owner of the byte-wide external RAM/IO port.
- Serves two requesters: instruction fetch (one 32-bit word per request, from the fetch/icache path) and the load/store buffer (1/2/4-byte loads and stores).
- Serialises each request into byte cycles and arbitrates round-robin between the two requesters.
- Discards speculative work when the ROB clears the pipeline; an in-flight store always completes.

---
 rtl/mem_arbiter_pkg.sv | 33 +++
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the external memory port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MA_IDLE  = 2'd0,
    MA_IF_RD = 2'd1,
    MA_LS_RD = 2'd2,
    MA_LS_WR = 2'd3
  } ma_state_e;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_LS = 1'b1
  } grant_e;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;

  // addr[17:16] value that selects the memory-mapped IO region
  localparam logic [1:0] IO_REGION_HI = 2'b11;

  // Bytes moved per LSB request; the unused code 3 behaves as a word.
  function automatic logic [2:0] byte_count(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      LEN_W:   return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and RAM-side signals of the memory arbiter.
// slave = arbiter view, master = requesters plus RAM/UART view.
interface mem_arbiter_if;
  logic        rdy_in;
  logic        clear;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_data;

  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_len;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ready;
  logic [31:0] ls_rdata;

  logic        busy;

  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport slave (
    input  rdy_in, clear,
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_len, ls_addr, ls_wdata,
    input  mem_din, io_buffer_full,
    output if_ready, if_data, ls_ready, ls_rdata, busy,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output rdy_in, clear,
    output if_req, if_addr,
    output ls_req, ls_we, ls_len, ls_addr, ls_wdata,
    output mem_din, io_buffer_full,
    input  if_ready, if_data, ls_ready, ls_rdata, busy,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-wide external RAM/IO port owner: round-robin between instruction
// fetch and the load/store buffer, one byte per cycle.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// MA_IDLE   | no transfer; grant decided here (accept cycle A)
// MA_IF_RD  | fetch word: issue 4 addresses, collect bytes, pulse if_ready
// MA_LS_RD  | LSB load: issue N addresses, collect bytes, pulse ls_ready
// MA_LS_WR  | LSB store: write N bytes (IO stall aware), pulse ls_ready
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [1:0] IO_HI_BITS = IO_REGION_HI
) (
  input  logic          clk_in,
  input  logic          rst_in,
  mem_arbiter_if.slave  bus
);

  ma_state_e   r_state;
  grant_e      r_last_grant;
  logic [2:0]  r_cnt;
  logic [2:0]  r_n;
  logic [31:0] r_mem_a;
  logic [31:0] r_prev_a;
  logic [31:0] r_buf;
  logic [31:0] r_wdata;
  logic [31:0] r_if_data;
  logic [31:0] r_ls_rdata;

  logic        w_grant_if;
  logic        w_grant_ls;
  logic        w_last;
  logic        w_stall;
  logic        w_if_ready;
  logic        w_ls_ready;
  logic [1:0]  w_cap_idx;
  logic [1:0]  w_last_idx;
  logic [31:0] w_rd_word;
  logic [31:0] w_next_a;

  // A flush in IDLE holds off new grants; on contention the side not
  // granted last time wins.
  assign w_grant_if = bus.if_req && !bus.clear &&
                      (!bus.ls_req || (r_last_grant == GRANT_LS));
  assign w_grant_ls = bus.ls_req && !bus.clear &&
                      (!bus.if_req || (r_last_grant == GRANT_IF));

  // r_cnt counts issued addresses; reaching r_n means the last byte is on mem_din.
  assign w_last     = (r_cnt == r_n);
  assign w_stall    = (r_state == MA_LS_WR) && (r_mem_a[17:16] == IO_HI_BITS) &&
                      bus.io_buffer_full;
  assign w_cap_idx  = 2'(r_cnt - 3'd1);
  assign w_last_idx = 2'(r_n - 3'd1);
  // Drop the address to 0 once the final byte is issued so nothing past the
  // request is touched (matters for side-effecting IO reads).
  assign w_next_a   = ((r_cnt + 3'd1) == r_n) ? 32'd0 : r_mem_a + 32'd1;

  // Final byte arrives in the ready cycle, so it is merged straight from mem_din.
  assign w_rd_word  = r_buf | ({24'd0, bus.mem_din} << {w_last_idx, 3'b000});

  assign w_if_ready = bus.rdy_in && (r_state == MA_IF_RD) && w_last && !bus.clear;
  assign w_ls_ready = bus.rdy_in && w_last &&
                      (((r_state == MA_LS_RD) && !bus.clear) || (r_state == MA_LS_WR));

  assign bus.if_ready = w_if_ready;
  assign bus.ls_ready = w_ls_ready;
  assign bus.if_data  = w_if_ready ? w_rd_word : r_if_data;
  assign bus.ls_rdata = (w_ls_ready && (r_state == MA_LS_RD)) ? w_rd_word : r_ls_rdata;
  assign bus.busy     = (r_state != MA_IDLE);
  assign bus.mem_dout = r_wdata[7:0];
  assign bus.mem_wr   = bus.rdy_in && (r_state == MA_LS_WR) && !w_last && !w_stall;
  // While frozen, re-present the previous address so mem_din still carries
  // the byte the capture logic expects when rdy_in returns.
  assign bus.mem_a    = bus.rdy_in ? r_mem_a : r_prev_a;

  // Arbitration FSM with byte counter, read assembly and write shifting.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= MA_IDLE;
      r_last_grant <= GRANT_IF;
      r_cnt        <= 3'd0;
      r_n          <= 3'd0;
      r_mem_a      <= 32'd0;
      r_prev_a     <= 32'd0;
      r_buf        <= 32'd0;
      r_wdata      <= 32'd0;
      r_if_data    <= 32'd0;
      r_ls_rdata   <= 32'd0;
    end else if (bus.rdy_in) begin
      r_prev_a <= r_mem_a;
      unique case (r_state)
        MA_IDLE: begin
          if (w_grant_ls) begin
            r_state      <= bus.ls_we ? MA_LS_WR : MA_LS_RD;
            r_last_grant <= GRANT_LS;
            r_mem_a      <= bus.ls_addr;
            r_wdata      <= bus.ls_wdata;
            r_n          <= byte_count(bus.ls_len);
            r_cnt        <= 3'd0;
            r_buf        <= 32'd0;
          end else if (w_grant_if) begin
            r_state      <= MA_IF_RD;
            r_last_grant <= GRANT_IF;
            r_mem_a      <= bus.if_addr;
            r_n          <= 3'd4;
            r_cnt        <= 3'd0;
            r_buf        <= 32'd0;
          end
        end
        MA_IF_RD, MA_LS_RD: begin
          if (bus.clear) begin
            r_state <= MA_IDLE;
            r_mem_a <= 32'd0;
            r_cnt   <= 3'd0;
          end else if (w_last) begin
            r_state <= MA_IDLE;
            r_cnt   <= 3'd0;
            if (r_state == MA_IF_RD) r_if_data  <= w_rd_word;
            else                     r_ls_rdata <= w_rd_word;
          end else begin
            if (r_cnt != 3'd0) r_buf[{w_cap_idx, 3'b000} +: 8] <= bus.mem_din;
            r_cnt   <= r_cnt + 3'd1;
            r_mem_a <= w_next_a;
          end
        end
        MA_LS_WR: begin
          if (w_last) begin
            r_state <= MA_IDLE;
            r_cnt   <= 3'd0;
          end else if (!w_stall) begin
            r_cnt   <= r_cnt + 3'd1;
            r_mem_a <= w_next_a;
            r_wdata <= r_wdata >> 8;
          end
        end
        default: r_state <= MA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-wide RAM model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   wr_count = 0;
  logic [7:0] ram [0:4095];

  logic [1:0]  t_len [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
  logic [31:0] t_adr [4] = '{32'h203, 32'h202, 32'h200, 32'h201};
  logic [31:0] t_exp [4] = '{32'h0000_00DE, 32'h0000_DEAD, 32'hDEAD_BEEF, 32'h00DE_ADBE};
  int          t_lat [4] = '{2, 3, 5, 5};

  mem_arbiter_if bus();

  mem_arbiter dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // RAM: data appears one cycle after its address; writes land on the edge.
  always @(posedge clk) begin
    bus.mem_din <= ram[bus.mem_a[11:0]];
    if (bus.mem_wr) begin
      ram[bus.mem_a[11:0]] <= bus.mem_dout;
      wr_count <= wr_count + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if ({bus.if_ready, bus.ls_ready, bus.mem_wr} !== 3'b000) begin miscompares++; $display("FAIL reset_pulses: got %b want 000", {bus.if_ready, bus.ls_ready, bus.mem_wr}); end
    vectors++; if (bus.mem_a !== 32'h0) begin miscompares++; $display("FAIL reset_mem_a: got %h want 0", bus.mem_a); end
    vectors++; if ({bus.if_data, bus.ls_rdata, bus.mem_dout} !== 72'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0", {bus.if_data, bus.ls_rdata, bus.mem_dout}); end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    bus.if_addr = 32'h100;
    bus.if_req  = 1'b1;
    #1;
    vectors++; if ({bus.busy, bus.mem_wr} !== 2'b00) begin miscompares++; $display("FAIL fetch_accept: got %b want 00", {bus.busy, bus.mem_wr}); end
    for (int k = 0; k < 4; k++) begin
      step(); #1;
      vectors++; if (bus.mem_a !== 32'h100 + 32'(k)) begin miscompares++; $display("FAIL fetch_addr%0d: got %h want %h", k, bus.mem_a, 32'h100 + 32'(k)); end
      vectors++; if ({bus.mem_wr, bus.if_ready} !== 2'b00) begin miscompares++; $display("FAIL fetch_early%0d: got %b want 00", k, {bus.mem_wr, bus.if_ready}); end
    end
    step(); #1;
    vectors++; if (bus.if_ready !== 1'b1) begin miscompares++; $display("FAIL fetch_ready: got %b want 1", bus.if_ready); end
    vectors++; if (bus.if_data !== 32'h0010_0513) begin miscompares++; $display("FAIL fetch_data: got %h want 00100513", bus.if_data); end
    bus.if_req = 1'b0;
    step(); #1;
    vectors++; if ({bus.if_ready, bus.busy} !== 2'b00) begin miscompares++; $display("FAIL fetch_after: got %b want 00", {bus.if_ready, bus.busy}); end
    vectors++; if (bus.if_data !== 32'h0010_0513) begin miscompares++; $display("FAIL fetch_hold: got %h want 00100513", bus.if_data); end
  endtask

  task automatic test_contention();
    int ls_at = 0, if_at = 0, ls_n = 0, if_n = 0;
    logic [31:0] ls_val = '0, if_val = '0, first_a = '0;
    do_reset();
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    bus.ls_addr = 32'h200; bus.ls_we = 1'b0; bus.ls_len = 2'd2; bus.ls_req = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      step(); #1;
      if (i == 1) first_a = bus.mem_a;
      if (bus.ls_ready) begin ls_n++; ls_at = i; ls_val = bus.ls_rdata; bus.ls_req = 1'b0; end
      if (bus.if_ready) begin if_n++; if_at = i; if_val = bus.if_data; bus.if_req = 1'b0; end
    end
    vectors++; if (first_a !== 32'h200) begin miscompares++; $display("FAIL cont_first: got %h want 200", first_a); end
    vectors++; if (ls_n !== 1 || ls_at !== 5) begin miscompares++; $display("FAIL cont_ls: got %0d pulses at %0d want 1 at 5", ls_n, ls_at); end
    vectors++; if (ls_val !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL cont_ls_data: got %h want deadbeef", ls_val); end
    vectors++; if (if_n !== 1 || if_at !== 11) begin miscompares++; $display("FAIL cont_if: got %0d pulses at %0d want 1 at 11", if_n, if_at); end
    vectors++; if (if_val !== 32'h0010_0513) begin miscompares++; $display("FAIL cont_if_data: got %h want 00100513", if_val); end
  endtask

  task automatic test_load_lengths();
    for (int t = 0; t < 4; t++) begin
      int at = 0;
      logic [31:0] val = '0;
      bus.ls_we = 1'b0; bus.ls_len = t_len[t]; bus.ls_addr = t_adr[t]; bus.ls_req = 1'b1;
      for (int i = 1; i <= 6; i++) begin
        step(); #1;
        if (bus.ls_ready) begin at = i; val = bus.ls_rdata; bus.ls_req = 1'b0; end
      end
      vectors++; if (at !== t_lat[t]) begin miscompares++; $display("FAIL load%0d_lat: got %0d want %0d", t, at, t_lat[t]); end
      vectors++; if (val !== t_exp[t]) begin miscompares++; $display("FAIL load%0d_data: got %h want %h", t, val, t_exp[t]); end
    end
  endtask

  task automatic test_store_half();
    int w0 = wr_count;
    bus.ls_we = 1'b1; bus.ls_len = 2'd1; bus.ls_addr = 32'h1000; bus.ls_wdata = 32'hABCD_1234; bus.ls_req = 1'b1;
    step(); #1;
    vectors++; if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h1000, 8'h34}) begin miscompares++; $display("FAIL sth_b0: got %b %h %h want 1 1000 34", bus.mem_wr, bus.mem_a, bus.mem_dout); end
    step(); #1;
    vectors++; if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h1001, 8'h12}) begin miscompares++; $display("FAIL sth_b1: got %b %h %h want 1 1001 12", bus.mem_wr, bus.mem_a, bus.mem_dout); end
    step(); #1;
    vectors++; if ({bus.ls_ready, bus.mem_wr} !== 2'b10) begin miscompares++; $display("FAIL sth_ready: got %b want 10", {bus.ls_ready, bus.mem_wr}); end
    bus.ls_req = 1'b0;
    step(); #1;
    vectors++; if (wr_count - w0 !== 2) begin miscompares++; $display("FAIL sth_count: got %0d want 2", wr_count - w0); end
    vectors++; if ({ram[12'h002], ram[12'h001], ram[12'h000]} !== 24'h00_1234) begin miscompares++; $display("FAIL sth_ram: got %h want 001234", {ram[12'h002], ram[12'h001], ram[12'h000]}); end
  endtask

  task automatic test_io_stall();
    int w0 = wr_count;
    bus.io_buffer_full = 1'b1;
    bus.ls_we = 1'b1; bus.ls_len = 2'd0; bus.ls_addr = 32'h3_0000; bus.ls_wdata = 32'h0000_005A; bus.ls_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step(); #1;
      vectors++; if ({bus.mem_wr, bus.mem_a} !== {1'b0, 32'h3_0000}) begin miscompares++; $display("FAIL io_stall%0d: got %b %h want 0 30000", i, bus.mem_wr, bus.mem_a); end
    end
    step();
    bus.io_buffer_full = 1'b0;
    #1;
    vectors++; if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h3_0000, 8'h5A}) begin miscompares++; $display("FAIL io_write: got %b %h %h want 1 30000 5a", bus.mem_wr, bus.mem_a, bus.mem_dout); end
    step(); #1;
    vectors++; if ({bus.ls_ready, bus.mem_wr} !== 2'b10) begin miscompares++; $display("FAIL io_ready: got %b want 10", {bus.ls_ready, bus.mem_wr}); end
    bus.ls_req = 1'b0;
    step(); #1;
    vectors++; if (wr_count - w0 !== 1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL io_done: got %0d writes busy %b want 1 writes busy 0", wr_count - w0, bus.busy); end
  endtask

  task automatic test_clear_fetch();
    int pulses = 0;
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    step();
    step();
    bus.clear = 1'b1; bus.if_req = 1'b0;
    #1;
    vectors++; if (bus.if_ready !== 1'b0) begin miscompares++; $display("FAIL clrf_a2: got %b want 0", bus.if_ready); end
    step();
    bus.if_req = 1'b1;
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL clrf_idle: got busy %b want 0", bus.busy); end
    step(); #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL clrf_block: got busy %b want 0", bus.busy); end
    bus.clear = 1'b0; bus.if_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      if (bus.if_ready) pulses++;
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL clrf_pulses: got %0d want 0", pulses); end
  endtask

  task automatic test_clear_store();
    int w0 = wr_count;
    bus.ls_we = 1'b1; bus.ls_len = 2'd2; bus.ls_addr = 32'h1010; bus.ls_wdata = 32'h1122_3344; bus.ls_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      bus.clear = (i == 2);
      #1;
      vectors++; if (bus.mem_wr !== (i <= 4)) begin miscompares++; $display("FAIL clrs_wr%0d: got %b want %b", i, bus.mem_wr, (i <= 4)); end
      vectors++; if (bus.ls_ready !== (i == 5)) begin miscompares++; $display("FAIL clrs_rdy%0d: got %b want %b", i, bus.ls_ready, (i == 5)); end
      if (bus.ls_ready) bus.ls_req = 1'b0;
    end
    bus.clear = 1'b0;
    vectors++; if (wr_count - w0 !== 4) begin miscompares++; $display("FAIL clrs_count: got %0d want 4", wr_count - w0); end
    vectors++; if ({ram[12'h013], ram[12'h012], ram[12'h011], ram[12'h010]} !== 32'h1122_3344) begin miscompares++; $display("FAIL clrs_ram: got %h want 11223344", {ram[12'h013], ram[12'h012], ram[12'h011], ram[12'h010]}); end
  endtask

  task automatic test_rdy_stall();
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      bus.rdy_in = !(i >= 2 && i <= 4);
      #1;
      vectors++; if (bus.if_ready !== (i == 8)) begin miscompares++; $display("FAIL rdy_pulse%0d: got %b want %b", i, bus.if_ready, (i == 8)); end
      if (bus.if_ready) begin
        vectors++; if (bus.if_data !== 32'h0010_0513) begin miscompares++; $display("FAIL rdy_data: got %h want 00100513", bus.if_data); end
        bus.if_req = 1'b0;
      end
    end
    bus.rdy_in = 1'b1;
  endtask

  task automatic test_reset_mid_load();
    bus.ls_we = 1'b0; bus.ls_len = 2'd2; bus.ls_addr = 32'h200; bus.ls_req = 1'b1;
    step();
    step();
    rst = 1'b1; bus.ls_req = 1'b0;
    step();
    rst = 1'b0;
    #1;
    vectors++; if ({bus.busy, bus.ls_ready, bus.if_ready, bus.mem_wr} !== 4'b0000) begin miscompares++; $display("FAIL rstm_flags: got %b want 0000", {bus.busy, bus.ls_ready, bus.if_ready, bus.mem_wr}); end
    vectors++; if ({bus.mem_a, bus.ls_rdata, bus.if_data, bus.mem_dout} !== 104'h0) begin miscompares++; $display("FAIL rstm_data: got %h want 0", {bus.mem_a, bus.ls_rdata, bus.if_data, bus.mem_dout}); end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) ram[a] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h10; ram[12'h103] = 8'h00;
    ram[12'h200] = 8'hEF; ram[12'h201] = 8'hBE; ram[12'h202] = 8'hAD; ram[12'h203] = 8'hDE;
    bus.rdy_in = 1'b1; bus.clear = 1'b0; bus.io_buffer_full = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_len = '0; bus.ls_addr = '0; bus.ls_wdata = '0;

    test_reset();
    test_fetch();
    test_contention();
    test_load_lengths();
    test_store_half();
    test_io_stall();
    test_clear_fetch();
    test_clear_store();
    test_rdy_stall();
    test_reset_mid_load();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
